// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: op-class and per-class op encodings,
// plus the multiply/divide sequencer states.
package alu_pkg;

  typedef enum logic [1:0] {ARITH, LOGIC, SHIFT, MULDIV} alu_class_e;

  typedef enum logic [1:0] {OP_ADD,  OP_SUB,   OP_SLT, OP_SLTU} arith_op_e;
  typedef enum logic [1:0] {OP_AND,  OP_OR,    OP_XOR, OP_NOR } logic_op_e;
  typedef enum logic [1:0] {OP_SLL,  OP_SRL,   OP_SRA, OP_ROR } shift_op_e;
  typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} muldiv_op_e;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} muldiv_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide on operand magnitudes, with a
// sign-fix cycle and the architectural HI/LO registers.
module muldiv_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  muldiv_op_e       op,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  muldiv_state_e state_q, state_d;

  logic             div_q, qneg_q, rneg_q;
  logic [WIDTH-1:0] opd_q, acc_hi_q, acc_lo_q;
  logic [CW-1:0]    cnt_q;

  logic             accept, is_signed, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] hi_fix, lo_fix;

  assign accept    = start && (state_q == IDLE || state_q == DONE);
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = is_signed && a[WIDTH-1];
  assign b_neg     = is_signed && b[WIDTH-1];
  assign mag_a     = a_neg ? -a : a;
  assign mag_b     = b_neg ? -b : b;

  assign mul_sum   = {1'b0, acc_hi_q} + {1'b0, opd_q};
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opd_q};

  assign busy = (state_q == RUN) || (state_q == FIX);
  assign done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prod   = {acc_hi_q, acc_lo_q};
    hi_fix = acc_hi_q;
    lo_fix = acc_lo_q;
    if (div_q) begin
      if (rneg_q) hi_fix = -acc_hi_q;
      if (qneg_q) lo_fix = -acc_lo_q;
    end else if (qneg_q) begin
      {hi_fix, lo_fix} = -prod;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FIX) begin
        hi <= hi_fix;
        lo <= lo_fix;
      end
    end
  end

  // A zero divisor leaves quotient all-ones and remainder |a|; suppressing the
  // quotient sign fix then yields lo='1, hi=a for signed and unsigned alike.
  always_ff @(posedge clk) begin
    if (accept) begin
      div_q    <= op[1];
      qneg_q   <= (a_neg ^ b_neg) && !(op[1] && b == '0);
      rneg_q   <= a_neg;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= op[1] ? mag_a : mag_b;
      opd_q    <= op[1] ? mag_b : mag_a;
    end else if (state_q == RUN) begin
      cnt_q <= cnt_q + 1'b1;
      if (div_q) begin
        if (!div_diff[WIDTH]) begin
          acc_hi_q <= div_diff[WIDTH-1:0];
          acc_lo_q <= {acc_lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi_q <= div_shift[WIDTH-1:0];
          acc_lo_q <= {acc_lo_q[WIDTH-2:0], 1'b0};
        end
      end else if (acc_lo_q[0]) begin
        {acc_hi_q, acc_lo_q} <= {mul_sum, acc_lo_q[WIDTH-1:1]};
      end else begin
        {acc_hi_q, acc_lo_q} <= {1'b0, acc_hi_q, acc_lo_q[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: single-cycle arithmetic/logic/shift classes with flags,
// and the iterative multiply/divide unit occupying class 3.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             start,
  output logic [WIDTH-1:0] y,
  output logic             C,
  output logic             S,
  output logic             Z,
  output logic             O,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  alu_class_e         cls;
  logic [SHW-1:0]     shamt;
  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] rot;
  logic               lt_s;

  assign cls   = alu_class_e'(s[3:2]);
  assign shamt = a[SHW-1:0];
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign rot   = {b, b} >> shamt;
  assign lt_s  = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : diff[WIDTH-1];

  muldiv_unit #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .op    (muldiv_op_e'(s[1:0])),
    .start (start && cls == MULDIV),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always_comb begin
    y = '0;
    C = 1'b0;
    O = 1'b0;
    case (cls)
      ARITH: begin
        // diff[WIDTH] is the borrow of a-b; carry reads as its complement
        C = ~diff[WIDTH];
        case (arith_op_e'(s[1:0]))
          OP_ADD: begin
            y = sum[WIDTH-1:0];
            C = sum[WIDTH];
            O = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
          end
          OP_SUB: begin
            y = diff[WIDTH-1:0];
            O = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
          end
          OP_SLT:  y = {{(WIDTH-1){1'b0}}, lt_s};
          default: y = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
        endcase
      end
      LOGIC: begin
        case (logic_op_e'(s[1:0]))
          OP_AND:  y = a & b;
          OP_OR:   y = a | b;
          OP_XOR:  y = a ^ b;
          default: y = ~(a | b);
        endcase
      end
      SHIFT: begin
        case (shift_op_e'(s[1:0]))
          OP_SLL:  y = b << shamt;
          OP_SRL:  y = b >> shamt;
          OP_SRA:  y = $signed(b) >>> shamt;
          default: y = rot[WIDTH-1:0];
        endcase
      end
      default: y = lo;
    endcase
  end

  assign S = y[WIDTH-1];
  assign Z = (y == '0);

endmodule
